// File: rtl/sram_arbiter.sv
// Arbitrates the shared frame SRAM port between the alpha (read-only) and fill (read/write) engines.
// One transaction at a time; write = 2 cycles, read = READ_LAT+1 cycles after the grant decision.
module sram_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 1536,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alpha_en,
  input  logic              fill_en,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              f_req,
  input  logic              f_we,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [DATA_W-1:0] f_wdata,
  output logic              f_ack,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              sram_re,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(READ_LAT - 1);

  state_t     state;
  logic       owner_f;
  logic       last_f;
  logic       cur_we;
  logic [3:0] cnt;
  logic       ra;
  logic       rf;
  logic       pick_f;

  assign ra = a_req & alpha_en;
  assign rf = f_req & fill_en;
  // F wins when it is alone, or on a tie when A was served last.
  assign pick_f = rf & (~ra | ~last_f);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner_f    <= 1'b0;
      last_f     <= 1'b1;
      cur_we     <= 1'b0;
      cnt        <= '0;
      a_ack      <= 1'b0;
      f_ack      <= 1'b0;
      a_rvalid   <= 1'b0;
      f_rvalid   <= 1'b0;
      sram_re    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      a_ack    <= 1'b0;
      f_ack    <= 1'b0;
      a_rvalid <= 1'b0;
      f_rvalid <= 1'b0;
      sram_re  <= 1'b0;
      sram_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (ra | rf) begin
            state     <= ISSUE;
            owner_f   <= pick_f;
            cur_we    <= pick_f & f_we;
            sram_addr <= pick_f ? f_addr : a_addr;
            if (pick_f) sram_wdata <= f_wdata;
            sram_we   <= pick_f & f_we;
            sram_re   <= ~(pick_f & f_we);
            a_ack     <= ~pick_f;
            f_ack     <= pick_f;
          end
        end
        ISSUE: begin
          last_f <= owner_f;
          if (cur_we) begin
            state <= IDLE;
          end else begin
            state    <= WAIT;
            cnt      <= CNT_INIT;
            // With a one-cycle SRAM the first WAIT cycle already carries the data.
            a_rvalid <= (CNT_INIT == 4'd0) & ~owner_f;
            f_rvalid <= (CNT_INIT == 4'd0) & owner_f;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            cnt      <= cnt - 4'd1;
            a_rvalid <= (cnt == 4'd1) & ~owner_f;
            f_rvalid <= (cnt == 4'd1) & owner_f;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign a_rdata = a_rvalid ? sram_rdata : '0;
  assign f_rdata = f_rvalid ? sram_rdata : '0;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed + randomized bench for sram_arbiter against a transaction-level schedule model.
module tb_sram_arbiter;
  localparam int AW = 24;
  localparam int DW = 1536;
  localparam int L  = 2;
  localparam int NC = 2400;

  logic          clk = 1'b0;
  logic          rst;
  logic          alpha_en, fill_en;
  logic          a_req, a_ack, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_rdata;
  logic          f_req, f_we, f_ack, f_rvalid;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_wdata, f_rdata;
  logic          sram_re, sram_we, busy;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(L)) dut (
    .clk(clk), .rst(rst), .alpha_en(alpha_en), .fill_en(fill_en),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata), .f_ack(f_ack),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .sram_re(sram_re), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {64{a}} ^ {48{32'h5A5A_0F0F}};
  endfunction

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // SRAM: data for a read strobe appears L clock edges later; junk otherwise.
  logic [DW-1:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= sram_re ? pat(sram_addr) : rand_wide();
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign sram_rdata = pipe[L-1];

  // Model: per-cycle schedule of expected acks / rvalids (0 none, 1 A, 2 F).
  int            ack_k [NC];
  int            rv_k  [NC];
  int            cyc, free_at;
  logic          last_f;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  int            n_vec = 0, n_err = 0;
  int            ord[$];

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d: got %b want %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d: got(low128) %0h want(low128) %0h", tag, cyc, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk_b({tag, "_a_ack"}, a_ack, 1'b0);
    chk_b({tag, "_f_ack"}, f_ack, 1'b0);
    chk_b({tag, "_a_rvalid"}, a_rvalid, 1'b0);
    chk_b({tag, "_f_rvalid"}, f_rvalid, 1'b0);
    chk_b({tag, "_sram_re"}, sram_re, 1'b0);
    chk_b({tag, "_sram_we"}, sram_we, 1'b0);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_w({tag, "_sram_addr"}, DW'(sram_addr), '0);
    chk_w({tag, "_sram_wdata"}, sram_wdata, '0);
    chk_w({tag, "_a_rdata"}, a_rdata, '0);
    chk_w({tag, "_f_rdata"}, f_rdata, '0);
  endtask

  task automatic check_cycle();
    int  ak, rk;
    logic wr;
    ak = ack_k[cyc];
    rk = rv_k[cyc];
    wr = (ak == 2) && m_we;
    chk_b("a_ack", a_ack, ak == 1);
    chk_b("f_ack", f_ack, ak == 2);
    chk_b("sram_re", sram_re, (ak != 0) && !wr);
    chk_b("sram_we", sram_we, wr);
    if (ak != 0) chk_w("sram_addr", DW'(sram_addr), DW'(m_addr));
    if (wr) chk_w("sram_wdata", sram_wdata, m_wdata);
    chk_b("a_rvalid", a_rvalid, rk == 1);
    chk_b("f_rvalid", f_rvalid, rk == 2);
    chk_w("a_rdata", a_rdata, (rk == 1) ? pat(m_addr) : '0);
    chk_w("f_rdata", f_rdata, (rk == 2) ? pat(m_addr) : '0);
    chk_b("busy", busy, cyc < free_at);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  // Grant decision the DUT makes at the next edge, from the inputs now applied.
  task automatic commit();
    logic ra, rf, pf;
    if (cyc >= free_at) begin
      ra = a_req & alpha_en;
      rf = f_req & fill_en;
      if (ra | rf) begin
        if (ra && rf) pf = !last_f;
        else          pf = rf;
        last_f  = pf;
        m_addr  = pf ? f_addr : a_addr;
        m_we    = pf && f_we;
        m_wdata = f_wdata;
        ack_k[cyc+1] = pf ? 2 : 1;
        if (m_we) free_at = cyc + 2;
        else begin
          rv_k[cyc+1+L] = pf ? 2 : 1;
          free_at = cyc + 2 + L;
        end
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      commit();
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    for (int i = cyc; i < NC; i++) begin
      ack_k[i] = 0;
      rv_k[i]  = 0;
    end
    free_at = 0;
    last_f  = 1'b1;
    @(negedge clk);
    cyc++;
    chk_zero("rst_hold");
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    alpha_en = 0; fill_en = 0; a_req = 0; a_addr = '0;
    f_req = 0; f_we = 0; f_addr = '0; f_wdata = '0;
    for (int i = 0; i < NC; i++) begin
      ack_k[i] = 0;
      rv_k[i]  = 0;
    end
    cyc = 0; free_at = 0; last_f = 1'b1; m_addr = '0; m_we = 0; m_wdata = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Fill write
    fill_en = 1; f_req = 1; f_we = 1; f_addr = 24'h000100; f_wdata = '1;
    run(1);
    f_req = 0;
    run(2);

    // Alpha read with data return
    alpha_en = 1; a_req = 1; a_addr = 24'h00ABCD;
    run(1);
    a_req = 0;
    run(L + 1);

    // Reset in the middle of a read wait; its rvalid must never show up
    a_req = 1; a_addr = 24'h123456;
    run(1);
    a_req = 0;
    run(1);
    do_reset();
    run(L + 2);

    // Tie after reset: continuous requests alternate A,F,A,F
    a_req = 1; a_addr = 24'h000ACE; f_req = 1; f_we = 1; f_addr = 24'h000F0F; f_wdata = rand_wide();
    guard = 0;
    while (ord.size() < 4 && guard < 40) begin
      run(1);
      guard++;
      if (a_ack) ord.push_back(1);
      if (f_ack) ord.push_back(2);
    end
    chk_i("tie_grants", ord.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < ord.size()) chk_i("tie_order", ord[i], (i % 2 == 0) ? 1 : 2);
    a_req = 0; f_req = 0;
    run(L + 3);

    // Enable gating: masked alpha request is ignored until enabled
    alpha_en = 0; fill_en = 1; a_req = 1; a_addr = 24'h0BEEF0; f_req = 0;
    run(10);
    alpha_en = 1;
    run(1);
    a_req = 0;
    run(L + 2);

    // Fill read with enable dropped right after the grant
    fill_en = 1; f_req = 1; f_we = 0; f_addr = 24'h00C0DE;
    run(1);
    f_req = 0; fill_en = 0;
    run(L + 2);

    // Random traffic obeying the request/ack handshake
    alpha_en = 1; fill_en = 1;
    repeat (1500) begin
      if (ack_k[cyc] == 1 || !a_req) begin
        a_req = ($urandom_range(0, 2) == 0);
        a_addr = AW'($urandom);
      end else if ($urandom_range(0, 15) == 0) a_req = 0;
      if (ack_k[cyc] == 2 || !f_req) begin
        f_req = ($urandom_range(0, 2) == 0);
        f_we = $urandom_range(0, 1) == 1;
        f_addr = AW'($urandom);
        f_wdata = rand_wide();
      end else if ($urandom_range(0, 15) == 0) f_req = 0;
      if ($urandom_range(0, 15) == 0) alpha_en = ~alpha_en;
      if ($urandom_range(0, 15) == 0) fill_en = ~fill_en;
      run(1);
    end
    a_req = 0; f_req = 0;
    run(L + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
